// File: rtl/mux_nt1_rr_pkg.sv
// mux_nt1_pkg: shared constants and helpers for the N:1 registered multiplexer.
//   MODE_SEL / MODE_RR : values of the mode input
//   GRANT_CNT_W        : width of the optional accepted-transfer counter
//   clog2()            : index width helper, never returns less than 1
package mux_nt1_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   localparam int GRANT_CNT_W = 16;

   // Bits needed to index n items; a single-bit index is the floor so that
   // select ports never collapse to zero width.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int k = 0; k < 31; k++) begin
         if ((1 << r) < n) begin
            r = r + 1;
         end
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/mux_nt1_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req       in  NCH   request vector
//   last      in  SELW  most recently granted index; search starts at last+1
//   gnt       out SELW  granted index (0 when gnt_valid is low)
//   gnt_valid out 1     at least one request is active
module rr_arbiter
   import mux_nt1_pkg::*;
#(
   parameter  int NCH  = 4,
   localparam int SELW = clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] last,
   output logic [SELW-1:0] gnt,
   output logic            gnt_valid
);

   // Walk offsets 1..NCH from the pointer; the first hit wins. Offset NCH
   // wraps back onto last itself, so a lone requester that was just served
   // is still granted again.
   always_comb begin : search
      int idx;
      gnt       = '0;
      gnt_valid = 1'b0;
      idx       = 0;
      for (int k = 1; k <= NCH; k++) begin
         idx = (int'(last) + k) % NCH;
         if (!gnt_valid && req[SELW'(idx)]) begin
            gnt_valid = 1'b1;
            gnt       = SELW'(idx);
         end
      end
   end

endmodule

// File: rtl/mux_nt1_rr.sv
// mux_nt1_rr: parametrised NCH-channel, WIDTH-bit registered multiplexer with
// valid/ready on every input and a single-entry registered output stage.
//
// Ports:
//   clk        in  1          rising-edge clock
//   rst        in  1          synchronous reset, active-high
//   mode       in  1          MODE_SEL = explicit select, MODE_RR = round-robin
//   sel        in  SELW       channel index used in MODE_SEL
//   in_valid   in  NCH        per-channel valid
//   in_data    in  NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_ready   out NCH        per-channel accept strobe (combinational)
//   out_valid  out 1          output register holds a word
//   out_data   out WIDTH      registered data
//   out_ch     out SELW       channel that produced out_data
//   grant_cnt  out 16         accepted-transfer count, saturating
//                             (only with MUX_NT1_GRANT_CNT_EN defined)
//   out_ready  in  1          consumer accepts the word
//
// Build option: define MUX_NT1_GRANT_CNT_EN to add the grant_cnt port.
module mux_nt1_rr
   import mux_nt1_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int NCH   = 4,
   localparam int SELW  = clog2(NCH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mode,
   input  logic [SELW-1:0]        sel,
   input  logic [NCH-1:0]         in_valid,
   input  logic [NCH*WIDTH-1:0]   in_data,
   output logic [NCH-1:0]         in_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic [SELW-1:0]        out_ch,
`ifdef MUX_NT1_GRANT_CNT_EN
   output logic [GRANT_CNT_W-1:0] grant_cnt,
`endif
   input  logic                   out_ready
);

   logic [WIDTH-1:0] ch_data [NCH];

   logic             out_valid_reg;
   logic [WIDTH-1:0] out_data_reg;
   logic [SELW-1:0]  out_ch_reg;
   logic [SELW-1:0]  last_reg;

   logic             load_en;
   logic             sel_hit;
   logic [SELW-1:0]  rr_gnt;
   logic             rr_valid;
   logic [SELW-1:0]  gnt;
   logic             grant_valid;
   logic             accept;

   // Unpack the flat data bus and build one ready strobe per channel.
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
         assign in_ready[gi] = accept && (gnt == SELW'(gi));
      end
   endgenerate

   rr_arbiter #(
      .NCH (NCH)
   ) u_arb (
      .req       (in_valid),
      .last      (last_reg),
      .gnt       (rr_gnt),
      .gnt_valid (rr_valid)
   );

   // The output register can take a new word when empty or being drained
   // this cycle, which gives back-to-back transfers without a bubble.
   assign load_en = !out_valid_reg || out_ready;

   // An out-of-range select is simply no grant; the range test is kept so
   // non-power-of-two channel counts never index past in_valid.
   always_comb begin
      sel_hit = 1'b0;
      if (int'(sel) < NCH) begin
         sel_hit = in_valid[sel];
      end
   end

   always_comb begin
      gnt         = sel;
      grant_valid = sel_hit;
      if (mode == MODE_RR) begin
         gnt         = rr_gnt;
         grant_valid = rr_valid;
      end
   end

   // Nothing is accepted while reset is held, so no source sees a handshake
   // for a word that reset would discard.
   assign accept = !rst && load_en && grant_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_ch_reg    <= '0;
         last_reg      <= SELW'(NCH - 1);
      end else if (load_en) begin
         if (grant_valid) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= ch_data[gnt];
            out_ch_reg    <= gnt;
            // Explicit-select traffic leaves the fairness pointer alone so
            // round-robin resumes where it left off.
            if (mode == MODE_RR) begin
               last_reg <= gnt;
            end
         end else begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_ch    = out_ch_reg;

`ifdef MUX_NT1_GRANT_CNT_EN
   logic [GRANT_CNT_W-1:0] grant_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_reg <= '0;
      end else if (accept && (grant_cnt_reg != {GRANT_CNT_W{1'b1}})) begin
         grant_cnt_reg <= grant_cnt_reg + GRANT_CNT_W'(1);
      end
   end

   assign grant_cnt = grant_cnt_reg;
`endif

endmodule

// File: tb/tb_mux_nt1_rr.sv
// tb_mux_nt1_rr: directed self-checking bench for mux_nt1_rr (WIDTH=4, NCH=4).
// Expected in_ready / output values are queued when each step's stimulus is
// driven and popped when that step is checked.
module tb_mux_nt1_rr;
   import mux_nt1_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mode = MODE_SEL;
   logic [1:0]  sel = 2'd0;
   logic [3:0]  in_valid = 4'b1111;
   logic [15:0] in_data = 16'h0;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [3:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_ready = 1'b1;
`ifdef MUX_NT1_GRANT_CNT_EN
   logic [15:0] grant_cnt;
`endif

   always #5 clk = ~clk;

   mux_nt1_rr #(
      .WIDTH (4),
      .NCH   (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
`ifdef MUX_NT1_GRANT_CNT_EN
      .grant_cnt (grant_cnt),
`endif
      .out_ready (out_ready)
   );

   typedef struct packed {
      logic [3:0] rdy;
      logic       ov;
      logic [1:0] ch;
      logic [3:0] data;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic expect_out(input logic [3:0] rdy, input logic ov,
                             input logic [1:0] ch, input logic [3:0] d);
      exp_t e;
      e.rdy  = rdy;
      e.ov   = ov;
      e.ch   = ch;
      e.data = d;
      sb.push_back(e);
   endtask

   // Called just after an active edge with new inputs already driven:
   // checks in_ready mid-cycle, then the registered outputs after the edge.
   task automatic step(input string tag);
      exp_t e;
      #2;
      chk({tag, ".sb_nonempty"}, 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, ".in_ready"}, 16'(in_ready), 16'(e.rdy));
         @(posedge clk);
         #1;
         chk({tag, ".out_valid"}, 16'(out_valid), 16'(e.ov));
         chk({tag, ".out_ch"},    16'(out_ch),    16'(e.ch));
         chk({tag, ".out_data"},  16'(out_data),  16'(e.data));
         $display("step %-10s rdy=%b ov=%b ch=%0d data=%h", tag, e.rdy, out_valid, out_ch, out_data);
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // Reset held two cycles with every channel requesting.
      rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      in_data = {4'h3, 4'h2, 4'h1, 4'hA};
      expect_out(4'b0000, 1'b0, 2'd0, 4'h0); step("rst0");
      expect_out(4'b0000, 1'b0, 2'd0, 4'h0); step("rst1");

      // Explicit select, legacy 2:1 behaviour.
      rst = 1'b0; mode = MODE_SEL; sel = 2'd0;
      expect_out(4'b0001, 1'b1, 2'd0, 4'hA); step("sel0");
      sel = 2'd1;
      expect_out(4'b0010, 1'b1, 2'd1, 4'h1); step("sel1");
      sel = 2'd3; in_valid = 4'b0111;
      expect_out(4'b0000, 1'b0, 2'd1, 4'h1); step("sel3_inv");

      // Round-robin fairness; pointer still at reset value 3.
      mode = MODE_RR; in_valid = 4'b1111; in_data = {4'h8, 4'h7, 4'h6, 4'h5};
      expect_out(4'b0001, 1'b1, 2'd0, 4'h5); step("rr0");
      expect_out(4'b0010, 1'b1, 2'd1, 4'h6); step("rr1");
      expect_out(4'b0100, 1'b1, 2'd2, 4'h7); step("rr2");
      expect_out(4'b1000, 1'b1, 2'd3, 4'h8); step("rr3");
      expect_out(4'b0001, 1'b1, 2'd0, 4'h5); step("rr4");

      // Backpressure: one load, three stalled cycles, then no-bubble reload.
      expect_out(4'b0010, 1'b1, 2'd1, 4'h6); step("bp_load");
      out_ready = 1'b0;
      expect_out(4'b0000, 1'b1, 2'd1, 4'h6); step("bp_hold0");
      expect_out(4'b0000, 1'b1, 2'd1, 4'h6); step("bp_hold1");
      expect_out(4'b0000, 1'b1, 2'd1, 4'h6); step("bp_hold2");
      out_ready = 1'b1;
      expect_out(4'b0100, 1'b1, 2'd2, 4'h7); step("bp_release");

      // Move pointer to 3, then sparse requests on ch1/ch3 wrap 1,3,1.
      expect_out(4'b1000, 1'b1, 2'd3, 4'h8); step("ptr_to3");
      in_valid = 4'b1010;
      expect_out(4'b0010, 1'b1, 2'd1, 4'h6); step("sparse1");
      expect_out(4'b1000, 1'b1, 2'd3, 4'h8); step("sparse3");
      expect_out(4'b0010, 1'b1, 2'd1, 4'h6); step("sparse1b");

      // Explicit select of an idle channel empties the output.
      mode = MODE_SEL; sel = 2'd2;
      expect_out(4'b0000, 1'b0, 2'd1, 4'h6); step("sel2_inv");

      // Back to round-robin: pointer retained at 1, so ch2 is next.
      mode = MODE_RR; in_valid = 4'b1111;
      expect_out(4'b0100, 1'b1, 2'd2, 4'h7); step("rr_resume");

      // Reset mid-transfer: no ready, word dropped, pointer back to 3.
      rst = 1'b1;
      expect_out(4'b0000, 1'b0, 2'd0, 4'h0); step("rst_mid");
      rst = 1'b0;
      expect_out(4'b0001, 1'b1, 2'd0, 4'h5); step("post_rst");

`ifdef MUX_NT1_GRANT_CNT_EN
      rst = 1'b1;
      @(posedge clk); #1;
      chk("cnt_rst", grant_cnt, 16'h0000);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("cnt_10", grant_cnt, 16'd10);
      repeat (65524) @(posedge clk);
      #1;
      chk("cnt_fffe", grant_cnt, 16'hFFFE);
      repeat (3) @(posedge clk);
      #1;
      chk("cnt_sat", grant_cnt, 16'hFFFF);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("cnt_clr", grant_cnt, 16'h0000);
      rst = 1'b0;
`endif

      chk("sb_drained", 16'(sb.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
